regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised 2-read/2-write register file with registered reads, optional write-through bypass,
//  optional hardwired-zero entry 0, per-entry busy scoreboard and a sequential clear engine
//  (one entry per cycle, RAM-friendly). Sits between decode (reads/reservations) and writeback
//  (two result ports) in the datapath.
// PARAMETERS
//  DATA_W    16  data width of every entry and bus
//  ADDR_W     5  address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG   1  1: entry 0 reads 0, writes/reservations to it discarded, never busy
//  BYPASS     1  1: same-cycle write data forwarded to registered read; 0: read-before-write
// PORTS
//  clk       in   1       clock, all state updates on posedge
//  rst       in   1       synchronous reset, active-high
//  ready     out  1       1 = RUN state, ports accepted; 0 = clearing
//  clr_req   in   1       pulse: start clear of all entries + busy bits (RUN only)
//  ra_a      in   ADDR_W  read address A
//  ra_b      in   ADDR_W  read address B
//  rd_a      out  DATA_W  registered read data A
//  rd_b      out  DATA_W  registered read data B
//  busy_a    out  1       registered busy flag of ra_a entry, aligned with rd_a
//  busy_b    out  1       registered busy flag of ra_b entry, aligned with rd_b
//  wen0      in   1       write enable port 0
//  wa0       in   ADDR_W  write address port 0
//  wd0       in   DATA_W  write data port 0
//  wen1      in   1       write enable port 1 (priority over port 0)
//  wa1       in   ADDR_W  write address port 1
//  wd1       in   DATA_W  write data port 1
//  rsv_en    in   1       reserve: mark entry rsv_addr busy (pending producer)
//  rsv_addr  in   ADDR_W  entry to reserve
// BEHAVIOUR
//  States: CLEAR, RUN. Posedge with rst=1: state<=CLEAR, ptr<=0, ready<=0, rd_*<=0, busy_*<=0,
//   all busy bits<=0. rst overrides every other input.
//  CLEAR (rst=0), each edge: mem[ptr]<=0; if ptr==DEPTH-1 -> state<=RUN, ready<=1; else ptr++.
//   ready rises exactly DEPTH edges after rst deasserts. wen*, rsv_en, clr_req ignored;
//   rd_*/busy_* held 0.
//  RUN, clr_req=1: state<=CLEAR, ptr<=0, ready<=0, busy bits<=0 at that edge; writes/reserves
//   in that same cycle are dropped.
//  Writes (RUN): mem[waN]<=wdN when wenN. wa0==wa1 both enabled: wd1 stored. ZERO_REG=1 and
//   addr 0: discarded.
//  Reads, 1-cycle latency: rd_a<= (ZERO_REG && ra_a==0) ? 0 :
//   BYPASS && wen1 && wa1==ra_a ? wd1 : BYPASS && wen0 && wa0==ra_a ? wd0 : mem[ra_a] (old).
//   Same for B. Both ports may read the same address.
//  Scoreboard (RUN): write via either port clears busy[wa]; rsv_en sets busy[rsv_addr];
//   reserve and write to same entry same cycle -> busy stays 1 (new producer wins).
//  busy_a <= next-state busy[ra_a] (consistent with bypassed rd_a); ZERO_REG: entry 0 always 0.
//  No wrap issues: addresses are full-range; ptr wraps only by leaving CLEAR.
// TESTING
//  1 rst 1 cycle, DEPTH=32 -> ready=0 for 32 edges, 1 on 32nd; every entry reads 0.
//  2 wen0 wa0=3 wd0=16'hA5A5, ra_a=3 same cycle -> rd_a=A5A5 next edge (BYPASS=1);
//    BYPASS=0 -> 0, then A5A5 one cycle later.
//  3 wen0 wa0=7 wd0=1111 and wen1 wa1=7 wd1=2222 -> mem[7]=2222, rd_b on ra_b=7 =2222.
//  4 ZERO_REG=1: wen1 wa1=0 wd1=FFFF, rsv_en addr 0 -> rd_a(ra_a=0)=0, busy_a=0.
//  5 rsv_en addr 5 -> busy_a(ra_a=5)=1; later wen0 wa0=5 -> busy_a=0; rsv+write same cycle -> 1.
//  6 Write 9=1234 then clr_req mid-run with wen1 pending -> ready low next edge, 32 cycles later
//    ready=1, entry 9 reads 0, all busy 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Two-read/two-write register file with busy scoreboard and a one-entry-per-cycle clear engine.
// Latency: reads and busy flags are registered, 1 cycle; ready rises DEPTH edges after a clear starts.
// Backpressure: none on write/reserve ports; while ready is low all write, reserve and clear inputs are ignored.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ready_q;
    logic [DATA_W-1:0] rd_a_q, rd_b_q;
    logic [DATA_W-1:0] rd_a_d, rd_b_d;
    logic              busy_a_q, busy_b_q;
    logic              busy_a_d, busy_b_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Ports are only honoured in RUN; a clear request in the same cycle drops them.
    logic run_acc;
    logic we0, we1, rsv;

    assign run_acc = !rst && (state_q == ST_RUN) && !clr_req;
    assign we0     = run_acc && wen0   && !(ZERO_REG && (wa0 == '0));
    assign we1     = run_acc && wen1   && !(ZERO_REG && (wa1 == '0));
    assign rsv     = run_acc && rsv_en && !(ZERO_REG && (rsv_addr == '0));

    // Next-state scoreboard: writes retire a producer, a reservation in the same cycle re-arms it.
    always_comb begin
        busy_d = busy_q;
        if (state_q != ST_RUN || clr_req) begin
            busy_d = '0;
        end else begin
            if (we0) busy_d[wa0] = 1'b0;
            if (we1) busy_d[wa1] = 1'b0;
            if (rsv) busy_d[rsv_addr] = 1'b1;
        end
    end

    // Read muxes: old array contents, overridden by port 0 then port 1 forwarding, zero entry last.
    always_comb begin
        rd_a_d = mem_q[ra_a];
        rd_b_d = mem_q[ra_b];
        if (BYPASS && we0 && (wa0 == ra_a)) rd_a_d = wd0;
        if (BYPASS && we1 && (wa1 == ra_a)) rd_a_d = wd1;
        if (BYPASS && we0 && (wa0 == ra_b)) rd_b_d = wd0;
        if (BYPASS && we1 && (wa1 == ra_b)) rd_b_d = wd1;
        if (ZERO_REG && (ra_a == '0)) rd_a_d = '0;
        if (ZERO_REG && (ra_b == '0)) rd_b_d = '0;
        busy_a_d = busy_d[ra_a] && !(ZERO_REG && (ra_a == '0));
        busy_b_d = busy_d[ra_b] && !(ZERO_REG && (ra_b == '0));
    end

    // Control FSM: clear sweep, RUN-mode registered read outputs and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
            busy_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rd_a_q   <= '0;
                    rd_b_q   <= '0;
                    busy_a_q <= 1'b0;
                    busy_b_q <= 1'b0;
                    busy_q   <= '0;
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    rd_a_q   <= rd_a_d;
                    rd_b_q   <= rd_b_d;
                    busy_a_q <= busy_a_d;
                    busy_b_q <= busy_b_d;
                    busy_q   <= busy_d;
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage array: no reset so it maps onto RAM; the clear engine zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_CLEAR)) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (we0) mem_q[wa0] <= wd0;
            if (we1) mem_q[wa1] <= wd1;
        end
    end

    assign ready  = ready_q;
    assign rd_a   = rd_a_q;
    assign rd_b   = rd_b_q;
    assign busy_a = busy_a_q;
    assign busy_b = busy_b_q;

endmodule
